// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file read arbiter.
package regfile_arb_pkg;

  localparam int N_REQ      = 4;
  localparam int IDX_W      = $clog2(N_REQ);
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;

  typedef logic [IDX_W-1:0] gnt_idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;

  // Pointer starts at the last requester so requester 0 is searched first.
  localparam gnt_idx_t PTR_RESET = gnt_idx_t'(N_REQ - 1);

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after (ptr_i + 1) mod N_REQ.
module rr_pick
  import regfile_arb_pkg::*;
(
  input  req_vec_t req_i,
  input  gnt_idx_t ptr_i,
  output req_vec_t pick_o,
  output gnt_idx_t idx_o,
  output logic     valid_o
);

  gnt_idx_t cand;
  logic     found;

  always_comb begin
    pick_o = '0;
    idx_o  = ptr_i;
    cand   = ptr_i;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr_i + gnt_idx_t'(i);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        pick_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Four-requester read arbiter for an 8-entry register file with 2-cycle read latency.
// Optional macro RFARB_PRIO0_EN gives requester 0 fixed priority over a 1..3 round-robin.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] raddr3,
  output logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] muxout,
  output logic [N_REQ-1:0]  gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [N_REQ-1:0]  rvalid
);

  req_vec_t          gnt_q, gnt_d;
  req_vec_t          rvalid_q, rvalid_d;
  gnt_idx_t          ptr_q, ptr_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] raddr_arr [N_REQ];
  req_vec_t          elig, rr_req, rr_pick_v;
  gnt_idx_t          rr_idx, win_idx;
  logic              rr_valid;

  assign raddr_arr[0] = raddr0;
  assign raddr_arr[1] = raddr1;
  assign raddr_arr[2] = raddr2;
  assign raddr_arr[3] = raddr3;

  // A requester being granted this cycle sits out the next arbitration.
  assign elig = req & ~gnt_q;

`ifdef RFARB_PRIO0_EN
  assign rr_req = elig & ~req_vec_t'(1);
`else
  assign rr_req = elig;
`endif

  rr_pick u_rr_pick (
    .req_i  (rr_req),
    .ptr_i  (ptr_q),
    .pick_o (rr_pick_v),
    .idx_o  (rr_idx),
    .valid_o(rr_valid)
  );

  always_comb begin
    gnt_d   = '0;
    ptr_d   = ptr_q;
    win_idx = ptr_q;
`ifdef RFARB_PRIO0_EN
    if (elig[0]) begin
      gnt_d   = req_vec_t'(1);
      win_idx = '0;
    end else if (rr_valid) begin
      gnt_d   = rr_pick_v;
      win_idx = rr_idx;
      ptr_d   = rr_idx;
    end
`else
    if (rr_valid) begin
      gnt_d   = rr_pick_v;
      win_idx = rr_idx;
      ptr_d   = rr_idx;
    end
`endif
    sel_d    = (gnt_d != '0) ? raddr_arr[win_idx] : sel_q;
    rvalid_d = gnt_q;
    rdata_d  = (gnt_q != '0) ? muxout : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      ptr_q    <= PTR_RESET;
      sel_q    <= '0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign sel    = sel_q;
  assign rdata  = rdata_q;

endmodule
